sram_ctl: RTL and testbench
===========================

// Module: sram_ctl
// PURPOSE
//   Bridges the core's byte bus to an external 512Kx16 asynchronous SRAM (1 MB total).
//   Sits directly downstream of the core and replaces the ideal 1-cycle byte memory.
//   Inserts programmable wait states, handles byte lanes, and stalls the core via cpu_ready.
//   Holds a one-word read buffer so repeated reads of the same 16-bit word complete in 1 cycle.
// PARAMETERS
//   WAIT      2   SRAM access cycles per transaction (min 1); tRC/tWP in clock periods
// PORTS
//   clock         in   1   system clock (same clock as the core)
//   reset         in   1   synchronous, active-high
//   cpu_address   in   20  byte address from core
//   cpu_out       in   8   write data from core
//   cpu_wren      in   1   write request
//   cpu_rden      in   1   read request
//   cpu_data      out  8   read data to core; holds the last completed read
//   cpu_ready     out  1   1-cycle pulse: transaction complete
//   sram_addr     out  19  word address = cpu_address[19:1]
//   sram_dq_i     in   16  SRAM data in (from pad)
//   sram_dq_o     out  16  SRAM data out = {cpu_out,cpu_out}
//   sram_dq_oe    out  1   pad output enable
//   sram_ce_n     out  1   chip enable, active-low
//   sram_oe_n     out  1   output enable, active-low
//   sram_we_n     out  1   write enable, active-low
//   sram_ub_n     out  1   upper-byte enable (address[0]=1)
//   sram_lb_n     out  1   lower-byte enable (address[0]=0)
// BEHAVIOUR
//   Reset: ce_n/oe_n/we_n/ub_n/lb_n=1, dq_oe=0, ready=0, cpu_data=0, sram_addr=0, buffer invalid, state IDLE.
//   Reset mid-transaction aborts at the next edge: we_n returns high, nothing is committed to the buffer.
//   Handshake: core holds address, data, and request stable until cpu_ready. A request is sampled only in IDLE.
//   If wren and rden are both high, the write is taken.
//   States: IDLE -> SETUP -> ACCESS (WAIT cycles, counter) -> DONE -> IDLE; IDLE -> DONE on a buffer hit.
//   Read miss:
//     - SETUP drives addr, ce_n=0, oe_n=0, both byte enables low.
//     - Last ACCESS cycle latches sram_dq_i into the buffer (tag = address[19:1], valid=1).
//     - DONE: ready=1, cpu_data = address[0] ? buf[15:8] : buf[7:0].
//   Read hit (rden, valid, tag match): no SRAM cycle; DONE next cycle with ready=1.
//   Write:
//     - SETUP drives addr, dq_o, dq_oe=1, oe_n=1, we_n=1, and the selected byte enable low.
//     - ACCESS holds we_n=0 for WAIT cycles.
//     - DONE: we_n=1, addr/data/dq_oe held for hold time, ready=1.
//     - Write-through: on tag match with valid, the addressed buffer byte is updated; otherwise the buffer is unchanged.
//   Latency from request first seen in IDLE to ready:
//     - read miss / write = WAIT+2 cycles
//     - hit = 1 cycle
//   DONE -> IDLE always; the core may present the next request the cycle after ready (back-to-back OK).
//   A request that stays high after ready starts a new transaction in IDLE; the core must drop it.
//   In IDLE: ce_n=1, oe_n=1, we_n=1, dq_oe=0; ready never high outside DONE.
//   Address wrap: 20'hFFFFF maps to word 19'h7FFFF, upper byte; no carry logic.
// TESTING
//   1. Reset, WAIT=2, read 20'h08000 (SRAM word 16'hBEEF):
//      -> ready at cycle 4, cpu_data=8'hEF; oe_n low for cycles 1-3.
//   2. Then read 20'h08001:
//      -> hit; ready next cycle; cpu_data=8'hBE; ce_n stays 1.
//   3. Write 8'h5A to 20'h08001:
//      -> ub_n=0, lb_n=1, we_n low for exactly 2 cycles, dq_o=16'h5A5A;
//      -> following read 20'h08001 hits with 8'h5A.
//   4. wren and rden together at 20'h00010, data 8'h33:
//      -> write performed; no read captured; buffer unchanged (tag miss).
//   5. Assert reset during the ACCESS cycle of a write:
//      -> next edge: we_n=1, dq_oe=0, ready=0; next read re-fetches (buffer invalid).
//   6. Back-to-back reads 20'hFFFFF then 20'h00000:
//      -> sram_addr 19'h7FFFF then 19'h00000; both miss; ready pulses 5 cycles apart.

Source files
------------

// File: rtl/sram_ctl_if.sv
// Core-side byte bus between the CPU and the SRAM controller.
// master = core (drives request), slave = controller (returns data/ready).
interface sram_ctl_if;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_wren;
    logic        cpu_rden;
    logic [7:0]  cpu_data;
    logic        cpu_ready;

    modport master (
        output cpu_address, cpu_out, cpu_wren, cpu_rden,
        input  cpu_data, cpu_ready
    );

    modport slave (
        input  cpu_address, cpu_out, cpu_wren, cpu_rden,
        output cpu_data, cpu_ready
    );
endinterface

// File: rtl/sram_ctl.sv
// Byte-bus to 512Kx16 async SRAM bridge with wait states and 1-word read buffer.
// Ports: clock/reset (sync, active-high); cpu (sram_ctl_if.slave) byte bus;
//   sram_addr/sram_dq_i/sram_dq_o/sram_dq_oe and active-low ce/oe/we/ub/lb pins.
module sram_ctl #(
    parameter int WAIT = 2
) (
    input  logic        clock,
    input  logic        reset,
    sram_ctl_if.slave   cpu,
    output logic [18:0] sram_addr,
    input  logic [15:0] sram_dq_i,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);
    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           is_wr;
    logic           lane;
    logic [15:0]    buf_q;
    logic [18:0]    tag;
    logic           valid;

    logic           hit;
    logic           last;

    assign hit  = valid && (tag == cpu.cpu_address[19:1]);
    assign last = (cnt == CW'(WAIT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            is_wr         <= 1'b0;
            lane          <= 1'b0;
            buf_q         <= '0;
            tag           <= '0;
            valid         <= 1'b0;
            cpu.cpu_data  <= '0;
            cpu.cpu_ready <= 1'b0;
            sram_addr     <= '0;
            sram_dq_o     <= '0;
            sram_dq_oe    <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_ub_n     <= 1'b1;
            sram_lb_n     <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cpu.cpu_ready <= 1'b0;
                    lane          <= cpu.cpu_address[0];
                    if (cpu.cpu_wren) begin
                        // Write wins when both requests are raised.
                        state      <= SETUP;
                        is_wr      <= 1'b1;
                        sram_addr  <= cpu.cpu_address[19:1];
                        sram_dq_o  <= {cpu.cpu_out, cpu.cpu_out};
                        sram_dq_oe <= 1'b1;
                        sram_ce_n  <= 1'b0;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_ub_n  <= ~cpu.cpu_address[0];
                        sram_lb_n  <= cpu.cpu_address[0];
                    end else if (cpu.cpu_rden && hit) begin
                        state         <= DONE;
                        is_wr         <= 1'b0;
                        cpu.cpu_ready <= 1'b1;
                        cpu.cpu_data  <= cpu.cpu_address[0] ?
                                         buf_q[15:8] : buf_q[7:0];
                    end else if (cpu.cpu_rden) begin
                        state     <= SETUP;
                        is_wr     <= 1'b0;
                        sram_addr <= cpu.cpu_address[19:1];
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_ub_n <= 1'b0;
                        sram_lb_n <= 1'b0;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= '0;
                    if (is_wr) begin
                        sram_we_n <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (last) begin
                        state         <= DONE;
                        cpu.cpu_ready <= 1'b1;
                        if (is_wr) begin
                            // Keep ce/addr/data/lanes for write hold time.
                            sram_we_n <= 1'b1;
                            if (valid && tag == sram_addr) begin
                                if (lane) begin
                                    buf_q[15:8] <= sram_dq_o[15:8];
                                end else begin
                                    buf_q[7:0]  <= sram_dq_o[7:0];
                                end
                            end
                        end else begin
                            buf_q        <= sram_dq_i;
                            tag          <= sram_addr;
                            valid        <= 1'b1;
                            cpu.cpu_data <= lane ?
                                            sram_dq_i[15:8] : sram_dq_i[7:0];
                            sram_ce_n    <= 1'b1;
                            sram_oe_n    <= 1'b1;
                            sram_ub_n    <= 1'b1;
                            sram_lb_n    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    cpu.cpu_ready <= 1'b0;
                    sram_dq_oe    <= 1'b0;
                    sram_ce_n     <= 1'b1;
                    sram_oe_n     <= 1'b1;
                    sram_we_n     <= 1'b1;
                    sram_ub_n     <= 1'b1;
                    sram_lb_n     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctl.sv
// Scoreboard bench for sram_ctl: SRAM pin model, byte-level reference memory,
// directed scenarios followed by randomized traffic.
module tb_sram_ctl;
    localparam int WAIT = 2;

    logic        clock;
    logic        reset;
    logic [18:0] sram_addr;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    sram_ctl_if bus();

    sram_ctl #(.WAIT(WAIT)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu        (bus),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     n, act, exp, cyc);
        end
    endtask

    // ---------------- SRAM device model ----------------
    logic [15:0] sram [int];

    function automatic logic [15:0] init_word(input logic [18:0] w);
        int x;
        x = int'(w) * 40503 ^ 32'h1A5C3;
        return x[15:0];
    endfunction

    function automatic logic [15:0] sram_rd(input logic [18:0] w);
        if (sram.exists(int'(w))) return sram[int'(w)];
        return init_word(w);
    endfunction

    always @(negedge clock)
        sram_dq_i <= (!sram_ce_n && !sram_oe_n) ? sram_rd(sram_addr) : 16'h0;

    always @(posedge sram_we_n) begin
        if (sram_ce_n === 1'b0 && sram_dq_oe === 1'b1) begin
            logic [15:0] w;
            w = sram_rd(sram_addr);
            if (!sram_ub_n) w[15:8] = sram_dq_o[15:8];
            if (!sram_lb_n) w[7:0]  = sram_dq_o[7:0];
            sram[int'(sram_addr)] = w;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [int];
    bit          bv;
    logic [18:0] btag;

    function automatic logic [7:0] ref_byte(input logic [19:0] a);
        logic [15:0] w;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        w = init_word(a[19:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    typedef struct {
        bit          rd;
        bit          hit;
        logic [7:0]  data;
        logic [18:0] word;
        bit          a0;
        logic [7:0]  wdat;
        int          issue;
    } exp_t;

    exp_t sb[$];

    // Called just after a rising edge while the controller is idle.
    task automatic issue(input logic [19:0] a, input bit wr, input bit rd,
                         input logic [7:0] d);
        exp_t e;
        e.rd    = rd && !wr;
        e.hit   = e.rd && bv && (btag == a[19:1]);
        e.data  = ref_byte(a);
        e.word  = a[19:1];
        e.a0    = a[0];
        e.wdat  = d;
        e.issue = cyc;
        if (wr) ref_mem[int'(a)] = d;
        if (e.rd && !e.hit) begin
            bv   = 1'b1;
            btag = a[19:1];
        end
        sb.push_back(e);
        bus.cpu_address = a;
        bus.cpu_out     = d;
        bus.cpu_wren    = wr;
        bus.cpu_rden    = rd;
    endtask

    int t_ready;

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clock);
            if (bus.cpu_ready === 1'b1) ok = 1'b1;
        end
        t_ready = cyc;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got none expected pulse at %0d", cyc);
            sb.delete();
        end
        @(posedge clock);
        #1;
        bus.cpu_wren = 1'b0;
        bus.cpu_rden = 1'b0;
    endtask

    task automatic xfer(input logic [19:0] a, input bit wr, input bit rd,
                        input logic [7:0] d);
        issue(a, wr, rd, d);
        wait_ready();
    endtask

    // ---------------- monitor ----------------
    int          cnt_ce, cnt_oe, cnt_we;
    logic [18:0] cap_addr;
    logic        cap_ub, cap_lb;
    logic [15:0] cap_dq;
    logic        prev_rdy;

    always @(negedge clock) begin
        if (reset) begin
            cnt_ce   = 0;
            cnt_oe   = 0;
            cnt_we   = 0;
            prev_rdy = 1'b0;
        end else begin
            if (!sram_ce_n) cnt_ce++;
            if (!sram_oe_n) begin
                cnt_oe++;
                cap_addr = sram_addr;
            end
            if (!sram_we_n) begin
                cnt_we++;
                cap_addr = sram_addr;
                cap_ub   = sram_ub_n;
                cap_lb   = sram_lb_n;
                cap_dq   = sram_dq_o;
            end
            if (bus.cpu_ready === 1'b1) begin
                chk("ready_pulse_width", 32'(prev_rdy), 32'd0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_ready: got ready expected none at %0d",
                             cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.issue),
                        e.hit ? 32'd1 : 32'(WAIT + 2));
                    if (e.rd) chk("cpu_data", 32'(bus.cpu_data), 32'(e.data));
                    if (e.hit) begin
                        chk("hit_ce_idle", 32'(cnt_ce), 32'd0);
                    end else begin
                        chk("sram_addr", 32'(cap_addr), 32'(e.word));
                    end
                    chk("oe_cycles", 32'(cnt_oe),
                        (e.rd && !e.hit) ? 32'(WAIT + 1) : 32'd0);
                    chk("we_cycles", 32'(cnt_we),
                        e.rd ? 32'd0 : 32'(WAIT));
                    if (!e.rd) begin
                        chk("ub_n", 32'(cap_ub), 32'(!e.a0));
                        chk("lb_n", 32'(cap_lb), 32'(e.a0));
                        chk("dq_o", 32'(cap_dq), 32'({e.wdat, e.wdat}));
                    end
                end
                cnt_ce = 0;
                cnt_oe = 0;
                cnt_we = 0;
            end
            prev_rdy = bus.cpu_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [18:0] words [4];
        int t1;
        words[0] = 19'h04000;
        words[1] = 19'h04001;
        words[2] = 19'h7FFFF;
        words[3] = 19'h00000;

        sram[int'(19'h04000)]   = 16'hBEEF;
        ref_mem[int'(20'h08000)] = 8'hEF;
        ref_mem[int'(20'h08001)] = 8'hBE;
        bv   = 1'b0;
        btag = '0;

        reset           = 1'b1;
        bus.cpu_address = '0;
        bus.cpu_out     = '0;
        bus.cpu_wren    = 1'b0;
        bus.cpu_rden    = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_ub_lb", 32'({sram_ub_n, sram_lb_n}), 32'd3);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_cpu_data", 32'(bus.cpu_data), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        @(posedge clock);
        #1;

        xfer(20'h08000, 1'b0, 1'b1, 8'h00);
        xfer(20'h08001, 1'b0, 1'b1, 8'h00);
        xfer(20'h08001, 1'b1, 1'b0, 8'h5A);
        xfer(20'h08001, 1'b0, 1'b1, 8'h00);
        xfer(20'h00010, 1'b1, 1'b1, 8'h33);
        xfer(20'h08000, 1'b0, 1'b1, 8'h00);
        xfer(20'h00010, 1'b0, 1'b1, 8'h00);
        xfer(20'h08001, 1'b0, 1'b1, 8'h00);

        // Abort a write with reset during its access phase.
        issue(20'h08001, 1'b1, 1'b0, ref_byte(20'h08001));
        @(posedge clock);
        @(posedge clock);
        #1;
        reset        = 1'b1;
        bus.cpu_wren = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_ready", 32'(bus.cpu_ready), 32'd0);
        sb.delete();
        bv = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        xfer(20'h08001, 1'b0, 1'b1, 8'h00);

        // Back-to-back misses across the address wrap.
        xfer(20'hFFFFF, 1'b0, 1'b1, 8'h00);
        t1 = t_ready;
        xfer(20'h00000, 1'b0, 1'b1, 8'h00);
        chk("b2b_spacing", 32'(t_ready - t1), 32'd5);

        for (int n = 0; n < 200; n++) begin
            logic [19:0] a;
            bit          wr, rd;
            int          gap;
            if ($urandom_range(0, 3) != 0)
                a = {words[$urandom_range(0, 3)], 1'($urandom_range(0, 1))};
            else
                a = 20'($urandom);
            wr  = ($urandom_range(0, 2) == 0);
            rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
            xfer(a, wr, rd, 8'($urandom));
        end

        repeat (4) @(posedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
